// File: rtl/forward_select_ctrl.sv
// ============================================================================
// forward_select_ctrl
//   EX-stage operand forwarding selects and load-use stall control.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module forward_select_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  ex_valid,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] C_SEL_RF  = 2'd0;
  localparam logic [1:0] C_SEL_EXM = 2'd1;
  localparam logic [1:0] C_SEL_MWB = 2'd2;

  // The WB stage needs no tag here: the register file is write-first, so a
  // WB producer is already visible to the ID reader.
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_rw_q, ex_rw_d;
  logic                  ex_mr_q, ex_mr_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [1:0]            fwd_sel_a_q, fwd_sel_a_d;
  logic [1:0]            fwd_sel_b_q, fwd_sel_b_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  logic w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;
  logic w_src_a_ok, w_src_b_ok;
  logic w_hazard, w_stall, w_advance;

  always_comb begin
    w_src_a_ok  = id_rs_used & (id_rs != '0);
    w_src_b_ok  = id_rt_used & (id_rt != '0);
    w_ex_hit_a  = w_src_a_ok & ex_valid_q & ex_rw_q & (ex_rd_q == id_rs);
    w_ex_hit_b  = w_src_b_ok & ex_valid_q & ex_rw_q & (ex_rd_q == id_rt);
    w_mem_hit_a = w_src_a_ok & mem_valid_q & mem_rw_q & (mem_rd_q == id_rs);
    w_mem_hit_b = w_src_b_ok & mem_valid_q & mem_rw_q & (mem_rd_q == id_rt);

    w_hazard  = ex_mr_q & (w_ex_hit_a | w_ex_hit_b);
    w_stall   = w_hazard & id_valid & ~flush;
    w_advance = id_valid & ~w_stall & ~flush;

    // Stall, flush and empty ID all turn into an EX bubble.
    ex_valid_d  = w_advance;
    ex_rd_d     = id_rd;
    ex_rw_d     = w_advance & id_reg_write;
    ex_mr_d     = w_advance & id_mem_read;
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    mem_rw_d    = ex_rw_q;

    fwd_sel_a_d = C_SEL_RF;
    fwd_sel_b_d = C_SEL_RF;
    if (w_advance) begin
      // Newest producer wins: EX (becomes EX/MEM) over MEM (becomes MEM/WB).
      if (w_ex_hit_a)       fwd_sel_a_d = C_SEL_EXM;
      else if (w_mem_hit_a) fwd_sel_a_d = C_SEL_MWB;
      if (w_ex_hit_b)       fwd_sel_b_d = C_SEL_EXM;
      else if (w_mem_hit_b) fwd_sel_b_d = C_SEL_MWB;
    end

    stall_count_d = stall_count_q;
    if (w_stall && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= '0;
      ex_rw_q       <= 1'b0;
      ex_mr_q       <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_rd_q      <= '0;
      mem_rw_q      <= 1'b0;
      fwd_sel_a_q   <= C_SEL_RF;
      fwd_sel_b_q   <= C_SEL_RF;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      ex_rw_q       <= ex_rw_d;
      ex_mr_q       <= ex_mr_d;
      mem_valid_q   <= mem_valid_d;
      mem_rd_q      <= mem_rd_d;
      mem_rw_q      <= mem_rw_d;
      fwd_sel_a_q   <= fwd_sel_a_d;
      fwd_sel_b_q   <= fwd_sel_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall       = w_stall;
  assign fwd_sel_a   = fwd_sel_a_q;
  assign fwd_sel_b   = fwd_sel_b_q;
  assign ex_valid    = ex_valid_q;
  assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_forward_select_ctrl.sv
// ============================================================================
// tb_forward_select_ctrl
//   Directed bench with an in-flight-producer model for forward_select_ctrl.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_forward_select_ctrl;

  localparam int RW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic          ex_valid;
  logic [CW-1:0] stall_count;

  int vectors = 0;
  int errors  = 0;
  logic last_stall;

  forward_select_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .ex_valid(ex_valid), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Model: list of instructions that left ID, newest first (index 0 = one ahead).
  typedef struct {
    logic          v;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
  } prod_t;

  prod_t inflight[$];
  int    m_sel_a, m_sel_b, m_cnt;
  logic  m_ex_valid;

  function automatic int distance_of(input logic [RW-1:0] r, input logic used);
    if (!used || r == 0) return 0;
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].v && inflight[i].rw && inflight[i].rd == r) return i + 1;
    return 0;
  endfunction

  function automatic logic model_stall();
    if (!id_valid || flush || inflight.size() == 0) return 1'b0;
    if (!inflight[0].mr) return 1'b0;
    return (distance_of(id_rs, id_rs_used) == 1) || (distance_of(id_rt, id_rt_used) == 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight.delete();
      m_sel_a = 0; m_sel_b = 0; m_cnt = 0; m_ex_valid = 1'b0;
    end else begin
      prod_t p;
      logic  s, go;
      s  = model_stall();
      go = id_valid && !s && !flush;
      p.v = go; p.rd = id_rd; p.rw = go && id_reg_write; p.mr = go && id_mem_read;
      m_sel_a = go ? distance_of(id_rs, id_rs_used) : 0;
      m_sel_b = go ? distance_of(id_rt, id_rt_used) : 0;
      m_ex_valid = go;
      if (s && m_cnt < CMAX) m_cnt++;
      inflight.push_front(p);
      if (inflight.size() > 2) void'(inflight.pop_back());
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("m_stall", int'(stall), int'(model_stall()));
      check("m_sel_a", int'(fwd_sel_a), m_sel_a);
      check("m_sel_b", int'(fwd_sel_b), m_sel_b);
      check("m_ex_valid", int'(ex_valid), int'(m_ex_valid));
      check("m_count", int'(stall_count), m_cnt);
    end
  end

  task automatic drive(input logic v, input logic [RW-1:0] rs, input logic rsu,
                       input logic [RW-1:0] rt, input logic rtu,
                       input logic [RW-1:0] rd, input logic rw, input logic mr,
                       input logic fl);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  // Present one ID instruction for one cycle; outputs of it visible on return.
  task automatic issue(input logic v, input logic [RW-1:0] rs, input logic rsu,
                       input logic [RW-1:0] rt, input logic rtu,
                       input logic [RW-1:0] rd, input logic rw, input logic mr,
                       input logic fl);
    drive(v, rs, rsu, rt, rtu, rd, rw, mr, fl);
    #1 last_stall = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // ALU chain
    issue(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0);
    issue(1, 4'd3, 1, 4'd3, 1, 4'd5, 1, 0, 0);
    check("chain_stall", int'(last_stall), 0);
    check("chain_sel_a", int'(fwd_sel_a), 1);
    check("chain_sel_b", int'(fwd_sel_b), 1);
    check("chain_valid", int'(ex_valid), 1);

    // Distance 2
    issue(1, 4'd1, 1, 4'd1, 1, 4'd4, 1, 0, 0);
    nop();
    check("nop_valid", int'(ex_valid), 0);
    issue(1, 4'd4, 1, 4'd7, 1, 4'd8, 1, 0, 0);
    check("dist2_sel_a", int'(fwd_sel_a), 2);
    check("dist2_sel_b", int'(fwd_sel_b), 0);

    // Newest producer wins
    issue(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 0);
    issue(1, 4'd2, 1, 4'd0, 0, 4'd2, 1, 0, 0);
    issue(1, 4'd2, 1, 4'd9, 1, 4'd10, 1, 0, 0);
    check("prio_sel_a", int'(fwd_sel_a), 1);
    check("prio_sel_b", int'(fwd_sel_b), 0);

    // Load-use
    issue(1, 4'd1, 1, 4'd0, 0, 4'd6, 1, 1, 0);
    issue(1, 4'd6, 1, 4'd1, 1, 4'd11, 1, 0, 0);
    check("lu_stall", int'(last_stall), 1);
    check("lu_bubble", int'(ex_valid), 0);
    check("lu_count", int'(stall_count), 1);
    issue(1, 4'd6, 1, 4'd1, 1, 4'd11, 1, 0, 0);
    check("lu_restall", int'(last_stall), 0);
    check("lu_sel_a", int'(fwd_sel_a), 2);
    check("lu_valid", int'(ex_valid), 1);

    // Register 0 never forwards
    issue(1, 4'd1, 1, 4'd1, 1, 4'd0, 1, 1, 0);
    issue(1, 4'd0, 1, 4'd0, 1, 4'd12, 1, 0, 0);
    check("r0_stall", int'(last_stall), 0);
    check("r0_sel_a", int'(fwd_sel_a), 0);
    check("r0_sel_b", int'(fwd_sel_b), 0);

    // Flush overrides stall
    issue(1, 4'd1, 1, 4'd0, 0, 4'd6, 1, 1, 0);
    issue(1, 4'd6, 1, 4'd0, 0, 4'd13, 1, 0, 1);
    check("fl_stall", int'(last_stall), 0);
    check("fl_bubble", int'(ex_valid), 0);
    check("fl_count", int'(stall_count), 1);

    // Saturation: 16 more load-use pairs drive the counter past its maximum
    for (int k = 0; k < 16; k++) begin
      issue(1, 4'd1, 1, 4'd0, 0, 4'd6, 1, 1, 0);
      issue(1, 4'd0, 0, 4'd6, 1, 4'd13, 1, 0, 0);
      issue(1, 4'd0, 0, 4'd6, 1, 4'd13, 1, 0, 0);
    end
    check("sat_count", int'(stall_count), CMAX);
    check("sat_sel_b", int'(fwd_sel_b), 2);

    // Asynchronous reset mid-stream while a stall is pending
    issue(1, 4'd1, 1, 4'd0, 0, 4'd8, 1, 1, 0);
    drive(1, 4'd8, 1, 4'd0, 0, 4'd14, 1, 0, 0);
    #2;
    check("pre_rst_stall", int'(stall), 1);
    reset = 1'b1;
    #1;
    check("rst_stall", int'(stall), 0);
    check("rst_sel_a", int'(fwd_sel_a), 0);
    check("rst_sel_b", int'(fwd_sel_b), 0);
    check("rst_valid", int'(ex_valid), 0);
    check("rst_count", int'(stall_count), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    issue(1, 4'd8, 1, 4'd8, 1, 4'd14, 1, 0, 0);
    check("post_rst_stall", int'(last_stall), 0);
    check("post_rst_sel_a", int'(fwd_sel_a), 0);
    check("post_rst_valid", int'(ex_valid), 1);

    nop();
    nop();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
